// File: rtl/bram_pkg.sv
// Shared types and constants for the iCE40 256x16 block RAM write path.
// Used by bram_write_ctrl and, when BRAM_WR_CLEAR_EN is defined, bram_clear_seq.
package bram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 16;
  localparam int RAM_DEPTH  = 256;

  localparam logic [RAM_DATA_W-1:0] MASK_NONE = 16'h0000;

  // SB_RAM40_4K MASK is active-high "don't write", so a clear strobe bit masks its byte.
  function automatic logic [RAM_DATA_W-1:0] strb_to_mask(input logic [1:0] strb);
    return {{8{~strb[1]}}, {8{~strb[0]}}};
  endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Address counter for the full-array clear: walks 0..RAM_DEPTH-1 and flags the
// final entry. Only instantiated when BRAM_WR_CLEAR_EN is defined.
module bram_clear_seq
  import bram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  advance,
  output logic [RAM_ADDR_W-1:0] addr,
  output logic [RAM_ADDR_W-1:0] next_addr,
  output logic                  next_last,
  output logic                  last
);

  localparam logic [RAM_ADDR_W-1:0] LAST_ADDR = RAM_ADDR_W'(RAM_DEPTH - 1);

  // Saturates at the last entry so the walk can never wrap back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (start) begin
      addr <= '0;
    end else if (advance && !last) begin
      addr <= addr + 1'b1;
    end
  end

  assign last      = (addr == LAST_ADDR);
  assign next_addr = addr + 1'b1;
  assign next_last = (addr == LAST_ADDR - 1'b1);

endmodule

// File: rtl/bram_write_ctrl.sv
// Write-side controller for the 256x16 SB_RAM40_4K: 32-bit strobed writes split into
// two halfword writes. Optional full-array clear sequencer under BRAM_WR_CLEAR_EN.
module bram_write_ctrl
  import bram_pkg::*;
#(
  parameter int              WORD_ADDR_W = 7,
  parameter logic [15:0]     CLEAR_VALUE = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WORD_ADDR_W-1:0] req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [3:0]             req_strb,
  input  logic                   clear_start,
  output logic                   busy,
  output logic                   done,
  output logic [RAM_ADDR_W-1:0]  ram_waddr,
  output logic [RAM_DATA_W-1:0]  ram_wdata,
  output logic [RAM_DATA_W-1:0]  ram_mask,
  output logic                   ram_we,
  output logic                   ram_wclke
);

  state_t                  state;
  logic [WORD_ADDR_W-1:0]  addr_q;
  logic [15:0]             hi_data_q;
  logic [1:0]              hi_strb_q;

  assign req_ready = (state == IDLE) & ~rst;
  assign ram_wclke = ram_we;

`ifdef BRAM_WR_CLEAR_EN
  logic                  seq_start;
  logic                  seq_last;
  logic                  seq_next_last;
  logic [RAM_ADDR_W-1:0] seq_addr;
  logic [RAM_ADDR_W-1:0] seq_next_addr;

  assign seq_start = (state == IDLE) & clear_start;

  bram_clear_seq u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (seq_start),
    .advance   (state == CLEAR),
    .addr      (seq_addr),
    .next_addr (seq_next_addr),
    .next_last (seq_next_last),
    .last      (seq_last)
  );
`else
  logic [16:0] clear_unused;
  assign clear_unused = {clear_start, CLEAR_VALUE};
`endif

  // RAM outputs are loaded on the same edge that enters the state they belong to,
  // so each write is presented for exactly the cycle its state is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ram_mask  <= '0;
      ram_we    <= 1'b0;
      addr_q    <= '0;
      hi_data_q <= '0;
      hi_strb_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          ram_we <= 1'b0;
          done   <= 1'b0;
          busy   <= 1'b0;
`ifdef BRAM_WR_CLEAR_EN
          if (clear_start) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            ram_waddr <= '0;
            ram_wdata <= CLEAR_VALUE;
            ram_mask  <= MASK_NONE;
            ram_we    <= 1'b1;
          end else
`endif
          if (req_valid) begin
            state     <= WR_LO;
            busy      <= 1'b1;
            addr_q    <= req_addr;
            hi_data_q <= req_wdata[31:16];
            hi_strb_q <= req_strb[3:2];
            ram_waddr <= RAM_ADDR_W'({req_addr, 1'b0});
            ram_wdata <= req_wdata[15:0];
            ram_mask  <= strb_to_mask(req_strb[1:0]);
            ram_we    <= |req_strb[1:0];
          end
        end

        WR_LO: begin
          state     <= WR_HI;
          ram_waddr <= RAM_ADDR_W'({addr_q, 1'b1});
          ram_wdata <= hi_data_q;
          ram_mask  <= strb_to_mask(hi_strb_q);
          ram_we    <= |hi_strb_q;
          done      <= 1'b1;
        end

        WR_HI: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          ram_we <= 1'b0;
        end

        CLEAR: begin
`ifdef BRAM_WR_CLEAR_EN
          if (seq_last) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            ram_we <= 1'b0;
          end else begin
            ram_waddr <= seq_next_addr;
            ram_wdata <= CLEAR_VALUE;
            ram_mask  <= MASK_NONE;
            ram_we    <= 1'b1;
            done      <= seq_next_last;
          end
`else
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          ram_we <= 1'b0;
`endif
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_write_ctrl.sv
// Directed self-checking bench for bram_write_ctrl with a bit-masked SB_RAM40_4K model.
// The clear test runs the sequencer when BRAM_WR_CLEAR_EN is defined, else checks clear_start is ignored.
module tb_bram_write_ctrl;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic [6:0]  reqAddr;
  logic [31:0] reqWdata;
  logic [3:0]  reqStrb;
  logic        clearStart;
  logic        busy;
  logic        done;
  logic [7:0]  ramWaddr;
  logic [15:0] ramWdata;
  logic [15:0] ramMask;
  logic        ramWe;
  logic        ramWclke;

  logic [15:0] mem [256];
  int          nAsserts;
  int          nFail;

  bram_write_ctrl #(
    .WORD_ADDR_W (7),
    .CLEAR_VALUE (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (reqValid),
    .req_ready   (reqReady),
    .req_addr    (reqAddr),
    .req_wdata   (reqWdata),
    .req_strb    (reqStrb),
    .clear_start (clearStart),
    .busy        (busy),
    .done        (done),
    .ram_waddr   (ramWaddr),
    .ram_wdata   (ramWdata),
    .ram_mask    (ramMask),
    .ram_we      (ramWe),
    .ram_wclke   (ramWclke)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: a write port bit lands only where MASK is 0.
  always @(posedge clk) begin
    if (ramWe && ramWclke) begin
      for (int b = 0; b < 16; b++) begin
        if (!ramMask[b]) mem[ramWaddr][b] <= ramWdata[b];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [6:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic clr);
    reqValid   = valid;
    reqAddr    = addr;
    reqWdata   = wdata;
    reqStrb    = strb;
    clearStart = clr;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    nAsserts = 0;
    nFail    = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hAAAA;
    rst = 1'b1;
    applyStimulus(1'b0, 7'h00, 32'h0, 4'h0, 1'b0);
    nextCycle();
    nextCycle();

    $display("[TB] reset state");
    checkOutput("rst_we", ramWe, 1'b0);
    checkOutput("rst_wclke", ramWclke, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_waddr", ramWaddr, 8'h00);
    checkOutput("rst_wdata", ramWdata, 16'h0000);
    checkOutput("rst_mask", ramMask, 16'h0000);
    checkOutput("rst_ready_low", reqReady, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", reqReady, 1'b1);

    $display("[TB] full word write");
    applyStimulus(1'b1, 7'h05, 32'hDEADBEEF, 4'hF, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 7'h00, 32'h0, 4'h0, 1'b0);
    checkOutput("full_lo_waddr", ramWaddr, 8'h0A);
    checkOutput("full_lo_wdata", ramWdata, 16'hBEEF);
    checkOutput("full_lo_mask", ramMask, 16'h0000);
    checkOutput("full_lo_we", ramWe, 1'b1);
    checkOutput("full_lo_wclke", ramWclke, 1'b1);
    checkOutput("full_lo_done", done, 1'b0);
    checkOutput("full_lo_busy", busy, 1'b1);
    checkOutput("full_lo_ready", reqReady, 1'b0);
    nextCycle();
    checkOutput("full_hi_waddr", ramWaddr, 8'h0B);
    checkOutput("full_hi_wdata", ramWdata, 16'hDEAD);
    checkOutput("full_hi_we", ramWe, 1'b1);
    checkOutput("full_hi_done", done, 1'b1);
    nextCycle();
    checkOutput("full_end_we", ramWe, 1'b0);
    checkOutput("full_end_done", done, 1'b0);
    checkOutput("full_end_busy", busy, 1'b0);
    checkOutput("full_end_ready", reqReady, 1'b1);
    checkOutput("full_mem_lo", mem[8'h0A], 16'hBEEF);
    checkOutput("full_mem_hi", mem[8'h0B], 16'hDEAD);

    $display("[TB] partial strobe write");
    applyStimulus(1'b1, 7'h7F, 32'h11223344, 4'b0110, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 7'h00, 32'h0, 4'h0, 1'b0);
    checkOutput("part_lo_waddr", ramWaddr, 8'hFE);
    checkOutput("part_lo_wdata", ramWdata, 16'h3344);
    checkOutput("part_lo_mask", ramMask, 16'h00FF);
    checkOutput("part_lo_we", ramWe, 1'b1);
    nextCycle();
    checkOutput("part_hi_waddr", ramWaddr, 8'hFF);
    checkOutput("part_hi_mask", ramMask, 16'hFF00);
    checkOutput("part_hi_we", ramWe, 1'b1);
    nextCycle();
    checkOutput("part_mem_lo", mem[8'hFE], 16'h33AA);
    checkOutput("part_mem_hi", mem[8'hFF], 16'hAA22);

    $display("[TB] zero strobe write");
    applyStimulus(1'b1, 7'h10, 32'hFFFFFFFF, 4'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 7'h00, 32'h0, 4'h0, 1'b0);
    checkOutput("zero_lo_we", ramWe, 1'b0);
    checkOutput("zero_lo_busy", busy, 1'b1);
    checkOutput("zero_lo_done", done, 1'b0);
    nextCycle();
    checkOutput("zero_hi_we", ramWe, 1'b0);
    checkOutput("zero_hi_done", done, 1'b1);
    checkOutput("zero_hi_ready", reqReady, 1'b0);
    nextCycle();
    checkOutput("zero_end_ready", reqReady, 1'b1);
    checkOutput("zero_end_done", done, 1'b0);
    checkOutput("zero_mem_lo", mem[8'h20], 16'hAAAA);
    checkOutput("zero_mem_hi", mem[8'h21], 16'hAAAA);

    $display("[TB] back-to-back requests");
    applyStimulus(1'b1, 7'h02, 32'h01234567, 4'hF, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 7'h03, 32'h89ABCDEF, 4'hF, 1'b0);
    checkOutput("b2b_a_lo_waddr", ramWaddr, 8'h04);
    checkOutput("b2b_ready_c1", reqReady, 1'b0);
    nextCycle();
    checkOutput("b2b_a_hi_waddr", ramWaddr, 8'h05);
    checkOutput("b2b_ready_c2", reqReady, 1'b0);
    nextCycle();
    checkOutput("b2b_ready_c3", reqReady, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 7'h00, 32'h0, 4'h0, 1'b0);
    checkOutput("b2b_b_lo_waddr", ramWaddr, 8'h06);
    checkOutput("b2b_b_lo_wdata", ramWdata, 16'hCDEF);
    checkOutput("b2b_b_lo_we", ramWe, 1'b1);
    nextCycle();
    checkOutput("b2b_b_hi_waddr", ramWaddr, 8'h07);
    checkOutput("b2b_b_hi_done", done, 1'b1);
    nextCycle();
    checkOutput("b2b_mem_a_lo", mem[8'h04], 16'h4567);
    checkOutput("b2b_mem_a_hi", mem[8'h05], 16'h0123);
    checkOutput("b2b_mem_b_lo", mem[8'h06], 16'hCDEF);
    checkOutput("b2b_mem_b_hi", mem[8'h07], 16'h89AB);

`ifdef BRAM_WR_CLEAR_EN
    $display("[TB] clear sequence with competing request");
    applyStimulus(1'b1, 7'h08, 32'hCAFEF00D, 4'hF, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 7'h08, 32'hCAFEF00D, 4'hF, 1'b0);
    checkOutput("clr_ready", reqReady, 1'b0);
    checkOutput("clr_busy", busy, 1'b1);
    checkOutput("clr_mask", ramMask, 16'h0000);
    checkOutput("clr_wdata", ramWdata, 16'h0000);
    for (int i = 0; i < 256; i++) begin
      checkOutput("clr_waddr", ramWaddr, i);
      checkOutput("clr_we", ramWe, 1'b1);
      checkOutput("clr_done", done, (i == 255));
      nextCycle();
    end
    checkOutput("clr_end_busy", busy, 1'b0);
    checkOutput("clr_end_we", ramWe, 1'b0);
    checkOutput("clr_end_ready", reqReady, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 7'h00, 32'h0, 4'h0, 1'b0);
    checkOutput("clr_req_waddr", ramWaddr, 8'h10);
    checkOutput("clr_req_wdata", ramWdata, 16'hF00D);
    nextCycle();
    nextCycle();
    checkOutput("clr_mem_0", mem[8'h00], 16'h0000);
    checkOutput("clr_mem_fe", mem[8'hFE], 16'h0000);
    checkOutput("clr_mem_ff", mem[8'hFF], 16'h0000);
    checkOutput("clr_mem_req_lo", mem[8'h10], 16'hF00D);
    checkOutput("clr_mem_req_hi", mem[8'h11], 16'hCAFE);
`else
    $display("[TB] clear_start ignored without clear feature");
    applyStimulus(1'b1, 7'h08, 32'hCAFEF00D, 4'hF, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 7'h00, 32'h0, 4'h0, 1'b0);
    checkOutput("noclr_waddr", ramWaddr, 8'h10);
    checkOutput("noclr_wdata", ramWdata, 16'hF00D);
    checkOutput("noclr_we", ramWe, 1'b1);
    nextCycle();
    checkOutput("noclr_hi_waddr", ramWaddr, 8'h11);
    checkOutput("noclr_done", done, 1'b1);
    nextCycle();
    checkOutput("noclr_end_busy", busy, 1'b0);
    nextCycle();
    checkOutput("noclr_idle_we", ramWe, 1'b0);
    checkOutput("noclr_idle_busy", busy, 1'b0);
    checkOutput("noclr_mem_lo", mem[8'h10], 16'hF00D);
    checkOutput("noclr_mem_hi", mem[8'h11], 16'hCAFE);
    checkOutput("noclr_mem_0", mem[8'h00], 16'hAAAA);
`endif

    $display("[TB] reset during WR_LO");
    applyStimulus(1'b1, 7'h20, 32'h55556666, 4'hF, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 7'h00, 32'h0, 4'h0, 1'b0);
    checkOutput("rmid_lo_waddr", ramWaddr, 8'h40);
    checkOutput("rmid_lo_we", ramWe, 1'b1);
    rst = 1'b1;
    nextCycle();
    checkOutput("rmid_we", ramWe, 1'b0);
    checkOutput("rmid_done", done, 1'b0);
    checkOutput("rmid_busy", busy, 1'b0);
    rst = 1'b0;
    nextCycle();
    checkOutput("rmid_ready", reqReady, 1'b1);
    checkOutput("rmid_idle_we", ramWe, 1'b0);
    checkOutput("rmid_mem_lo", mem[8'h40], 16'h6666);
    checkOutput("rmid_mem_hi", mem[8'h41], 16'hAAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
